// File: rtl/ibex_imd_val_arbiter.sv
// ============================================================================
// Module  : ibex_imd_val_arbiter
// Purpose : Round-robin ownership arbiter for a shared intermediate-value array.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ibex_imd_val_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int WIDTH    = 34,
    parameter int DEPTH    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         release_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    input  logic [NUM_REQ*DEPTH-1:0]   we_i,
    input  logic [WIDTH-1:0]           wdata_i [NUM_REQ*DEPTH],
    output logic [WIDTH-1:0]           rdata_o [DEPTH],
    output logic                       busy_o,
    output logic                       preempt_o
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWNED = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [OW-1:0]      owner_q,   owner_d;
    logic [OW-1:0]      rr_q,      rr_d;
    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic [HW-1:0]      hold_q,    hold_d;
    logic               preempt_q, preempt_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];

    logic               win_found;
    logic [OW-1:0]      win_idx;
    logic               other_req;
    logic               owner_rel;
    logic               preempt_now;

    // Scan from the highest offset down so the offset closest to rr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[(int'(rr_q) + i) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = OW'((int'(rr_q) + i) % NUM_REQ);
            end
        end
    end

    // gnt_q is one-hot on the owner while OWNED, so it doubles as the owner mask.
    assign other_req   = |(req_i & ~gnt_q);
    assign owner_rel   = |(release_i & gnt_q);
    assign preempt_now = other_req && (hold_q == HW'(MAX_HOLD - 1)) && !owner_rel;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        mem_d     = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_OWNED;
                    owner_d = win_idx;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    hold_d  = '0;
                end
            end
            ST_OWNED: begin
                if (!preempt_now) begin
                    for (int r = 0; r < NUM_REQ; r++) begin
                        for (int e = 0; e < DEPTH; e++) begin
                            if (owner_q == OW'(r) && we_i[r*DEPTH+e]) begin
                                mem_d[e] = wdata_i[r*DEPTH+e];
                            end
                        end
                    end
                end
                if (owner_rel) begin
                    state_d = ST_CLEAR;
                    gnt_d   = '0;
                end else if (preempt_now) begin
                    state_d   = ST_CLEAR;
                    gnt_d     = '0;
                    preempt_d = 1'b1;
                end else if (other_req && hold_q != HW'(MAX_HOLD)) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_CLEAR: begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_d[e] = '0;
                end
                rr_d    = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
                hold_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_q      <= '0;
            gnt_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= mem_d[e];
            end
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign preempt_o = preempt_q;
    assign rdata_o   = mem_q;

endmodule

`default_nettype wire

// File: tb/tb_ibex_imd_val_arbiter.sv
// ============================================================================
// Module  : tb_ibex_imd_val_arbiter
// Purpose : Scoreboard bench for the intermediate-value ownership arbiter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ibex_imd_val_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [1:0]  release_i;
    logic [1:0]  gnt_o;
    logic [3:0]  we_i;
    logic [33:0] wdata_i [4];
    logic [33:0] rdata_o [2];
    logic        busy_o;
    logic        preempt_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  rel;
        logic [3:0]  we;
        logic [33:0] w0, w1, w2, w3;
    } stim_t;

    typedef struct {
        logic [1:0]  gnt;
        logic        busy;
        logic        pre;
        logic [33:0] d0, d1;
    } exp_t;

    exp_t sb [$];

    ibex_imd_val_arbiter #(
        .NUM_REQ (2),
        .WIDTH   (34),
        .DEPTH   (2),
        .MAX_HOLD(16)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .release_i(release_i),
        .gnt_o    (gnt_o),
        .we_i     (we_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .busy_o   (busy_o),
        .preempt_o(preempt_o)
    );

    always #5 clk = ~clk;

    function automatic stim_t S(logic rst, logic [1:0] req, logic [1:0] rel, logic [3:0] we,
                                logic [33:0] w0, logic [33:0] w1, logic [33:0] w2);
        stim_t s;
        s = '{rst: rst, req: req, rel: rel, we: we, w0: w0, w1: w1, w2: w2, w3: 34'h0};
        return s;
    endfunction

    function automatic exp_t X(logic [1:0] gnt, logic busy, logic pre, logic [33:0] d0, logic [33:0] d1);
        exp_t x;
        x = '{gnt: gnt, busy: busy, pre: pre, d0: d0, d1: d1};
        return x;
    endfunction

    task automatic apply(input stim_t s);
        rst_i      = s.rst;
        req_i      = s.req;
        release_i  = s.rel;
        we_i       = s.we;
        wdata_i[0] = s.w0;
        wdata_i[1] = s.w1;
        wdata_i[2] = s.w2;
        wdata_i[3] = s.w3;
    endtask

    task automatic do_reset();
        apply(S(1'b1, 2'b00, 2'b00, 4'h0, 34'h0, 34'h0, 34'h0));
        @(posedge clk); #1;
        apply(S(1'b0, 2'b00, 2'b00, 4'h0, 34'h0, 34'h0, 34'h0));
    endtask

    task automatic test_reset();
        stim_t s [$];
        exp_t  x [$];
        exp_t  e;
        s.push_back(S(1'b1, 2'b11, 2'b00, 4'hF, 34'h1, 34'h2, 34'h3)); x.push_back(X(2'b00, 0, 0, 0, 0));
        s.push_back(S(1'b1, 2'b11, 2'b11, 4'hF, 34'h1, 34'h2, 34'h3)); x.push_back(X(2'b00, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(x[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if ({gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1]} !== {e.gnt, e.busy, e.pre, e.d0, e.d1}) begin
                bad++;
                $display("FAIL reset step %0d: got gnt=%b busy=%b pre=%b d0=%h d1=%h, want gnt=%b busy=%b pre=%b d0=%h d1=%h",
                         i, gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1], e.gnt, e.busy, e.pre, e.d0, e.d1);
            end
        end
    endtask

    task automatic test_grant_write();
        stim_t s [$];
        exp_t  x [$];
        exp_t  e;
        do_reset();
        s.push_back(S(0, 2'b01, 2'b00, 4'b0000, 0, 0, 0));                    x.push_back(X(2'b01, 1, 0, 0, 0));
        s.push_back(S(0, 2'b01, 2'b00, 4'b0111, 34'h3_FFFF_FFFF, 34'h1, 34'h123)); x.push_back(X(2'b01, 1, 0, 34'h3_FFFF_FFFF, 34'h1));
        s.push_back(S(0, 2'b01, 2'b01, 4'b0000, 0, 0, 0));                    x.push_back(X(2'b00, 1, 0, 34'h3_FFFF_FFFF, 34'h1));
        s.push_back(S(0, 2'b00, 2'b00, 4'b0000, 0, 0, 0));                    x.push_back(X(2'b00, 0, 0, 0, 0));
        // Pointer has moved past requester 0, so a joint request now favours 1.
        s.push_back(S(0, 2'b11, 2'b00, 4'b0000, 0, 0, 0));                    x.push_back(X(2'b10, 1, 0, 0, 0));
        s.push_back(S(0, 2'b00, 2'b10, 4'b0000, 0, 0, 0));                    x.push_back(X(2'b00, 1, 0, 0, 0));
        s.push_back(S(0, 2'b00, 2'b00, 4'b0000, 0, 0, 0));                    x.push_back(X(2'b00, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(x[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if ({gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1]} !== {e.gnt, e.busy, e.pre, e.d0, e.d1}) begin
                bad++;
                $display("FAIL grant_write step %0d: got gnt=%b busy=%b pre=%b d0=%h d1=%h, want gnt=%b busy=%b pre=%b d0=%h d1=%h",
                         i, gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1], e.gnt, e.busy, e.pre, e.d0, e.d1);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s [$];
        exp_t  x [$];
        exp_t  e;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            s.push_back(S(0, 2'b11, 2'b00, 4'h0, 0, 0, 0)); x.push_back(X(2'b01, 1, 0, 0, 0));
        end
        s.push_back(S(0, 2'b11, 2'b01, 4'h0, 0, 0, 0)); x.push_back(X(2'b00, 1, 0, 0, 0));
        s.push_back(S(0, 2'b11, 2'b00, 4'h0, 0, 0, 0)); x.push_back(X(2'b00, 0, 0, 0, 0));
        s.push_back(S(0, 2'b11, 2'b00, 4'h0, 0, 0, 0)); x.push_back(X(2'b10, 1, 0, 0, 0));
        s.push_back(S(0, 2'b00, 2'b10, 4'h0, 0, 0, 0)); x.push_back(X(2'b00, 1, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(x[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if ({gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1]} !== {e.gnt, e.busy, e.pre, e.d0, e.d1}) begin
                bad++;
                $display("FAIL back_to_back step %0d: got gnt=%b busy=%b pre=%b d0=%h d1=%h, want gnt=%b busy=%b pre=%b d0=%h d1=%h",
                         i, gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1], e.gnt, e.busy, e.pre, e.d0, e.d1);
            end
        end
    endtask

    task automatic test_preempt();
        stim_t s [$];
        exp_t  x [$];
        exp_t  e;
        do_reset();
        s.push_back(S(0, 2'b11, 2'b00, 4'h0, 0, 0, 0)); x.push_back(X(2'b01, 1, 0, 0, 0));
        // Owned cycles 0..13: nothing; 14: write commits; 15: hold limit reached, write dropped.
        for (int j = 0; j < 14; j++) begin
            s.push_back(S(0, 2'b11, 2'b00, 4'h0, 0, 0, 0)); x.push_back(X(2'b01, 1, 0, 0, 0));
        end
        s.push_back(S(0, 2'b11, 2'b00, 4'b0001, 34'h55, 0, 0));      x.push_back(X(2'b01, 1, 0, 34'h55, 0));
        s.push_back(S(0, 2'b11, 2'b00, 4'b0001, 34'h0_DEAD, 0, 0));  x.push_back(X(2'b00, 1, 1, 34'h55, 0));
        s.push_back(S(0, 2'b11, 2'b00, 4'h0, 0, 0, 0)); x.push_back(X(2'b00, 0, 0, 0, 0));
        s.push_back(S(0, 2'b11, 2'b00, 4'h0, 0, 0, 0)); x.push_back(X(2'b10, 1, 0, 0, 0));
        s.push_back(S(0, 2'b00, 2'b10, 4'h0, 0, 0, 0)); x.push_back(X(2'b00, 1, 0, 0, 0));
        s.push_back(S(0, 2'b00, 2'b00, 4'h0, 0, 0, 0)); x.push_back(X(2'b00, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(x[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if ({gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1]} !== {e.gnt, e.busy, e.pre, e.d0, e.d1}) begin
                bad++;
                $display("FAIL preempt step %0d: got gnt=%b busy=%b pre=%b d0=%h d1=%h, want gnt=%b busy=%b pre=%b d0=%h d1=%h",
                         i, gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1], e.gnt, e.busy, e.pre, e.d0, e.d1);
            end
        end
    endtask

    task automatic test_release_vs_preempt();
        stim_t s [$];
        exp_t  x [$];
        exp_t  e;
        do_reset();
        s.push_back(S(0, 2'b11, 2'b00, 4'h0, 0, 0, 0)); x.push_back(X(2'b01, 1, 0, 0, 0));
        for (int j = 0; j < 15; j++) begin
            s.push_back(S(0, 2'b11, 2'b00, 4'h0, 0, 0, 0)); x.push_back(X(2'b01, 1, 0, 0, 0));
        end
        s.push_back(S(0, 2'b11, 2'b01, 4'b0001, 34'h77, 0, 0)); x.push_back(X(2'b00, 1, 0, 34'h77, 0));
        s.push_back(S(0, 2'b00, 2'b00, 4'h0, 0, 0, 0));         x.push_back(X(2'b00, 0, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(x[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if ({gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1]} !== {e.gnt, e.busy, e.pre, e.d0, e.d1}) begin
                bad++;
                $display("FAIL release_vs_preempt step %0d: got gnt=%b busy=%b pre=%b d0=%h d1=%h, want gnt=%b busy=%b pre=%b d0=%h d1=%h",
                         i, gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1], e.gnt, e.busy, e.pre, e.d0, e.d1);
            end
        end
    endtask

    task automatic test_reset_mid_owned();
        stim_t s [$];
        exp_t  x [$];
        exp_t  e;
        do_reset();
        // Move the pointer to 1 first so the post-reset grant proves it was cleared.
        s.push_back(S(0, 2'b01, 2'b00, 4'h0, 0, 0, 0));            x.push_back(X(2'b01, 1, 0, 0, 0));
        s.push_back(S(0, 2'b01, 2'b01, 4'h0, 0, 0, 0));            x.push_back(X(2'b00, 1, 0, 0, 0));
        s.push_back(S(0, 2'b00, 2'b00, 4'h0, 0, 0, 0));            x.push_back(X(2'b00, 0, 0, 0, 0));
        s.push_back(S(0, 2'b10, 2'b00, 4'h0, 0, 0, 0));            x.push_back(X(2'b10, 1, 0, 0, 0));
        s.push_back(S(0, 2'b10, 2'b00, 4'b1100, 0, 0, 34'h11));    x.push_back(X(2'b10, 1, 0, 34'h11, 0));
        s.push_back(S(1, 2'b10, 2'b00, 4'h0, 0, 0, 0));            x.push_back(X(2'b00, 0, 0, 0, 0));
        s.push_back(S(0, 2'b11, 2'b00, 4'h0, 0, 0, 0));            x.push_back(X(2'b01, 1, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]); sb.push_back(x[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if ({gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1]} !== {e.gnt, e.busy, e.pre, e.d0, e.d1}) begin
                bad++;
                $display("FAIL reset_mid_owned step %0d: got gnt=%b busy=%b pre=%b d0=%h d1=%h, want gnt=%b busy=%b pre=%b d0=%h d1=%h",
                         i, gnt_o, busy_o, preempt_o, rdata_o[0], rdata_o[1], e.gnt, e.busy, e.pre, e.d0, e.d1);
            end
        end
    endtask

    initial begin
        apply(S(1'b1, 2'b00, 2'b00, 4'h0, 34'h0, 34'h0, 34'h0));
        test_reset();
        test_grant_write();
        test_back_to_back();
        test_preempt();
        test_release_vs_preempt();
        test_reset_mid_owned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
